blk_mem_ctrl: RTL

- Clocked block-granular main-memory controller downstream of the cache; serves the cache's miss refills and dirty/write-through write-backs.
- Holds 64 blocks of 128 bits (16 bytes each), addressed by a 10-bit byte address.
- Replaces the zero-latency combinational memory model with a valid/ready request/response handshake and a configurable access latency, so cache miss handling sees realistic stalls.
- Keeps saturating read/write access counters for hit-rate and traffic measurement.

---
 rtl/blk_mem_ctrl.sv | 120 ++++++++++++
 1 files changed

// File: rtl/blk_mem_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | blk_mem_ctrl: 64 x 128-bit block memory with valid/ready handshake and   |
// | fixed access latency, plus saturating read/write counters.  Rev 1.0      |
// +--------------------------------------------------------------------------+
module blk_mem_ctrl #(
  parameter int LATENCY = 4,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [9:0]       req_addr,
  input  logic [127:0]     req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [127:0]     resp_rdata,
  output logic             resp_write,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count
);

  localparam int BLOCKS = 64;
  localparam int LAT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LAT_W-1:0]  lat_cnt;
  logic              lat_done;
  logic              accept;
  logic              resp_done;
  logic              pend_write;
  logic [5:0]        pend_blk;
  logic [127:0]      pend_wdata;
  logic [127:0]      mem [BLOCKS];
  logic              unused_addr_bits;

  // The low nibble selects a byte within a block and is irrelevant here.
  assign unused_addr_bits = ^req_addr[3:0];

  assign req_ready = (state == IDLE);
  assign accept    = req_valid & req_ready;
  assign resp_done = resp_valid & resp_ready;
  assign lat_done  = (lat_cnt == '0);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = WAIT;
      WAIT:    if (lat_done)  state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt    <= '0;
      pend_write <= 1'b0;
      pend_blk   <= '0;
      pend_wdata <= '0;
      resp_valid <= 1'b0;
      resp_write <= 1'b0;
      resp_rdata <= '0;
      rd_count   <= '0;
      wr_count   <= '0;
      for (int i = 0; i < BLOCKS; i++) mem[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            pend_write <= req_write;
            pend_blk   <= req_addr[9:4];
            pend_wdata <= req_wdata;
            lat_cnt    <= LAT_W'(LATENCY - 1);
            if (req_write) begin
              if (wr_count != '1) wr_count <= wr_count + CNT_W'(1);
            end else begin
              if (rd_count != '1) rd_count <= rd_count + CNT_W'(1);
            end
          end
        end
        WAIT: begin
          if (lat_done) begin
            // Write commits before its response, so a following read sees it.
            if (pend_write) begin
              mem[pend_blk] <= pend_wdata;
              resp_rdata    <= '0;
            end else begin
              resp_rdata    <= mem[pend_blk];
            end
            resp_write <= pend_write;
            resp_valid <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end
        RESP: begin
          if (resp_ready) resp_valid <= 1'b0;
        end
        default: resp_valid <= 1'b0;
      endcase
    end
  end

endmodule
`default_nettype wire
